// File: rtl/mio_wait_mem_if.sv
// rtl/mio_wait_mem_if.sv - SCPU MIO request/response bundle between the CPU and the wait-state memory.
interface mio_wait_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  CPU_MIO;
    logic                  MemRW;
    logic [ADDR_W-1:0]     Addr_out;
    logic [DATA_W-1:0]     Data_out;
    logic [DATA_W/8-1:0]   wr_be;
    logic [DATA_W-1:0]     Data_in;
    logic                  MIO_ready;
    logic                  err;
    logic                  busy;

    modport master (
        output CPU_MIO, MemRW, Addr_out, Data_out, wr_be,
        input  Data_in, MIO_ready, err, busy
    );

    modport slave (
        input  CPU_MIO, MemRW, Addr_out, Data_out, wr_be,
        output Data_in, MIO_ready, err, busy
    );
endinterface

// File: rtl/mio_wait_mem.sv
// rtl/mio_wait_mem.sv - Word RAM on the MIO bus with byte strobes, wait states and fault flagging.
module mio_wait_mem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mio_wait_mem_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   data_in_q;
    logic                ready_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                   commit;
    logic                   fault;
    logic [DEPTH_LOG2-1:0]  idx;

    assign commit = (state_q == S_RESP);
    assign idx    = addr_q[DEPTH_LOG2+1:2];
    // Upper address bits beyond the array make the word index out of range.
    assign fault  = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:DEPTH_LOG2+2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            S_IDLE: begin
                if (bus.CPU_MIO) begin
                    we_d    = bus.MemRW;
                    addr_d  = bus.Addr_out;
                    wdata_d = bus.Data_out;
                    be_d    = bus.wr_be;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The response is registered on the edge leaving RESP, so MIO_ready lands in the next IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            data_in_q <= '0;
        end else begin
            ready_q <= commit;
            if (commit) begin
                err_q <= fault;
                if (fault) begin
                    data_in_q <= '0;
                end else if (!we_q) begin
                    data_in_q <= mem[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && we_q && !fault) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.Data_in   = data_in_q;
    assign bus.MIO_ready = ready_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
